// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU controller slice: the function codes the
// controller understands, the all-ones idle code that selects nothing, the
// controller state type and two small helpers for decoding function codes.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [5:0] FN_AND    = 6'b100100;
   localparam logic [5:0] FN_OR     = 6'b100101;
   localparam logic [5:0] FN_ADD    = 6'b100000;
   localparam logic [5:0] FN_SUB    = 6'b100010;
   localparam logic [5:0] FN_SLT    = 6'b101010;
   localparam logic [5:0] FN_SLL    = 6'b000000;
   localparam logic [5:0] FN_DIVU   = 6'b011011;
   localparam logic [5:0] FN_MFHI   = 6'b010000;
   localparam logic [5:0] FN_MFLO   = 6'b010010;

   // All-ones is not a legal function code, so driving it onto a unit's
   // function input tells that unit nothing is being asked of it.
   localparam logic [5:0] IDLE_CODE = 6'b111111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_DIV_WAIT,
      ST_DONE
   } state_t;

   // Operations that are carried out by the ALU proper
   function automatic logic is_alu_op(input logic [5:0] f);
      case (f)
         FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: is_alu_op = 1'b1;
         default:                               is_alu_op = 1'b0;
      endcase
   endfunction

   // Every code the controller knows how to sequence
   function automatic logic is_supported(input logic [5:0] f);
      case (f)
         FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT,
         FN_SLL, FN_DIVU, FN_MFHI, FN_MFLO:    is_supported = 1'b1;
         default:                              is_supported = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_div_counter.sv
// ---------------------------------------------------------------------------
// alu_div_counter
// Six-bit cycle counter used to time the multi-cycle divider.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset, clears the count
//   clear  - synchronous clear, has priority over en
//   en     - increment the count this cycle
//   count  - current count value
//   tc     - high while count equals TERMINAL
// ---------------------------------------------------------------------------
module alu_div_counter #(
   parameter int TERMINAL = 31
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       en,
   output logic [5:0] count,
   output logic       tc
);

   localparam logic [5:0] TC_VALUE = 6'(TERMINAL);

   // The count restarts from zero whenever the controller is not waiting on
   // the divider, so every divide starts counting from a clean zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 6'd0;
      end else if (clear) begin
         count <= 6'd0;
      end else if (en) begin
         count <= count + 6'd1;
      end
   end

   // Terminal-count flag is decoded straight from the registered count
   assign tc = (count == TC_VALUE);

endmodule

// File: rtl/alu_ctrl.sv
// ---------------------------------------------------------------------------
// alu_ctrl
// Sequencing controller for the ALU, shifter and multi-cycle divider.
// A request is latched in IDLE; single-cycle operations complete in one EXEC
// cycle, DIVU waits DIV_CYCLES cycles for the divider and then writes HI/LO
// in a DONE cycle. Every output is decoded from registered state only.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset
//   start      - request valid, only looked at in IDLE
//   funct      - function code of the request
//   busy       - high whenever the controller is not IDLE
//   done       - one-cycle completion pulse
//   err        - one-cycle pulse alongside done for an unsupported code
//   alu_sig    - function code to the ALU (idle code when unused)
//   sht_sig    - function code to the shifter (idle code when unused)
//   div_sig    - function code to the divider (idle code when unused)
//   mux_sig    - result mux select (idle code when nothing is selected)
//   div_start  - one-cycle pulse that launches the divider
//   hilo_we    - one-cycle write enable for the HI/LO pair
// ---------------------------------------------------------------------------
module alu_ctrl
   import alu_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [5:0] funct,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [5:0] alu_sig,
   output logic [5:0] sht_sig,
   output logic [5:0] div_sig,
   output logic [5:0] mux_sig,
   output logic       div_start,
   output logic       hilo_we
);

   state_t     state;
   state_t     state_nxt;
   logic [5:0] op_q;
   logic [5:0] div_count;
   logic       div_tc;

   // The divide timer only runs while waiting on the divider and is held at
   // zero otherwise, so it reads zero in the first DIV_WAIT cycle.
   alu_div_counter #(
      .TERMINAL (DIV_CYCLES - 1)
   ) u_div_counter (
      .clk   (clk),
      .reset (reset),
      .clear (state != ST_DIV_WAIT),
      .en    (state == ST_DIV_WAIT),
      .count (div_count),
      .tc    (div_tc)
   );

   // State and latched opcode. The opcode is only captured when a request
   // is accepted in IDLE, so a start while busy leaves it untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         op_q  <= IDLE_CODE;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && start) begin
            op_q <= funct;
         end
      end
   end

   // Next-state logic. Unsupported codes still take the EXEC path so the
   // requester gets a done/err handshake instead of a hang.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = (funct == FN_DIVU) ? ST_DIV_WAIT : ST_EXEC;
            end
         end
         ST_EXEC:     state_nxt = ST_IDLE;
         ST_DIV_WAIT: begin
            if (div_tc) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE:     state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // Output decode from state and the latched opcode. Every unit sees the
   // idle code unless the current operation is meant for it. The divide
   // result lands in HI/LO, so DONE selects nothing on the result mux.
   always_comb begin
      done      = 1'b0;
      err       = 1'b0;
      alu_sig   = IDLE_CODE;
      sht_sig   = IDLE_CODE;
      div_sig   = IDLE_CODE;
      mux_sig   = IDLE_CODE;
      div_start = 1'b0;
      hilo_we   = 1'b0;
      case (state)
         ST_EXEC: begin
            done    = 1'b1;
            mux_sig = op_q;
            if (!is_supported(op_q)) begin
               err = 1'b1;
            end else if (is_alu_op(op_q)) begin
               alu_sig = op_q;
            end else if (op_q == FN_SLL) begin
               sht_sig = op_q;
            end
         end
         ST_DIV_WAIT: begin
            div_sig   = FN_DIVU;
            div_start = (div_count == 6'd0);
         end
         ST_DONE: begin
            done    = 1'b1;
            hilo_we = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter: DIV_CYCLES, 32, number of cycles the divider needs between div_start and a valid HI/LO result.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request valid; sampled only in IDLE.
REQ-005 funct  input  6  function code of the requested operation.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse; result is valid at the output mux this cycle.
REQ-008 err  output  1  one-cycle pulse with done when the latched funct is unsupported.
REQ-009 alu_sig  output  6  function code to the ALU.
REQ-010 sht_sig  output  6  function code to the shifter.
REQ-011 div_sig  output  6  function code to the divider.
REQ-012 mux_sig  output  6  select code to the result mux.
REQ-013 div_start  output  1  one-cycle pulse starting a divide.
REQ-014 hilo_we  output  1  one-cycle write enable for the HI/LO register pair.

Function
REQ-015 Supported codes: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SLL 000000, DIVU 011011, MFHI 010000, MFLO 010010; all others are unsupported.
REQ-016 States: IDLE, EXEC, DIV_WAIT, DONE; encoding is free.
REQ-017 IDLE: start=1 latches funct into op_q; DIVU -> DIV_WAIT; any other code -> EXEC; start=0 -> stay.
REQ-018 start while busy is ignored; funct is not re-sampled until IDLE.
REQ-019 EXEC lasts exactly one cycle with done=1, then returns to IDLE; single-cycle latency is therefore start edge + 1 cycle.
REQ-020 In EXEC: AND/OR/ADD/SUB/SLT drive alu_sig=op_q; SLL drives sht_sig=op_q; MFHI/MFLO drive neither; mux_sig=op_q for all supported codes.
REQ-021 Unsupported code in EXEC: done=1, err=1, mux_sig=op_q, alu_sig/sht_sig/div_sig=000000-equivalent idle value 111111.
REQ-022 Outputs not being driven for an operation hold 111111 (idle code, selects nothing).
REQ-023 DIV_WAIT: div_sig=DIVU throughout; div_start=1 in the first DIV_WAIT cycle only; a 6-bit counter clears on entry and increments each cycle.
REQ-024 DIV_WAIT exits to DONE on the cycle the counter equals DIV_CYCLES-1 (DIV_WAIT lasts DIV_CYCLES cycles).
REQ-025 DONE lasts one cycle: hilo_we=1, done=1, mux_sig=111111 (divide writes HI/LO, produces no bus result), then IDLE.
REQ-026 Total DIVU latency: accept edge to done = DIV_CYCLES+1 cycles.
REQ-027 done, err, div_start, hilo_we are never high for more than one consecutive cycle.
REQ-028 All outputs are registered-state decoded; no combinational path from start/funct to any output.

Reset
REQ-029 reset=1 forces IDLE, counter=0, op_q=111111 on the next edge, overriding any transition.
REQ-030 Reset values: busy=0, done=0, err=0, div_start=0, hilo_we=0, all *_sig=111111.
REQ-031 reset during DIV_WAIT aborts the divide: no hilo_we, no done.

Structure
REQ-032 Shared package alu_pkg holds the funct code constants, the idle code 111111 and the state typedef; the output mux uses the same constants.
REQ-033 Sub-module alu_div_counter (load-clear, enable, terminal-count flag) is natural; the rest is one FSM process plus output decode.

Verification
REQ-034 start=1, funct=100000 in IDLE -> next cycle alu_sig=100000, mux_sig=100000, done=1, busy=1; following cycle busy=0.
REQ-035 start=1, funct=011011 -> div_start pulse on cycle 1, busy high 33 cycles, hilo_we=1 and done=1 together on cycle 33, err=0.
REQ-036 start=1, funct=000010 (SRL) -> cycle 1 done=1, err=1, alu_sig=sht_sig=div_sig=111111.
REQ-037 DIVU accepted, then start=1 funct=100100 on cycle 5 -> ignored; no second done; next IDLE request completes normally.
REQ-038 reset=1 on cycle 10 of a DIVU -> next cycle all outputs at reset values; no hilo_we ever asserted.
REQ-039 Back-to-back: start held high with funct=010000 -> done pulses every second cycle, mux_sig=010000 on each done.
